// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types for the UART TX frame sequencer: line-mux select, FSM states and
// the registered control bundle decoded from each state.
package uart_tx_ctrl_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_STOP   = 2'd1,
        SEL_DATA   = 2'd2,
        SEL_PARITY = 2'd3
    } tx_mux_sel_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef struct packed {
        logic        busy;
        logic        ser_en;
        tx_mux_sel_t mux_sel;
    } tx_ctl_t;

    // Moore decode; registered alongside the state so outputs never glitch.
    function automatic tx_ctl_t ctl_of(input tx_state_t s);
        tx_ctl_t c;
        c = '{busy: 1'b1, ser_en: 1'b0, mux_sel: SEL_STOP};
        case (s)
            TX_IDLE:   c.busy = 1'b0;
            TX_START:  c.mux_sel = SEL_START;
            TX_DATA: begin
                c.mux_sel = SEL_DATA;
                c.ser_en  = 1'b1;
            end
            TX_PARITY: c.mux_sel = SEL_PARITY;
            default:   c.mux_sel = SEL_STOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake/control bundle between the TX top (master) and the frame sequencer (slave).
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = uart_tx_ctrl_pkg::DATA_WIDTH
) ();
    import uart_tx_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_done;
    logic                  ser_en;
    tx_mux_sel_t           mux_sel;
    logic                  par_bit;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
        input  ser_en, mux_sel, par_bit, busy, frame_done
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done,
        output ser_en, mux_sel, par_bit, busy, frame_done
    );

endinterface

// File: rtl/uart_tx_ctrl_parity.sv
// Parity generator: even parity when odd=0, odd parity when odd=1.
module uart_tx_ctrl_parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             par
);

    assign par = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: START, DATA (serializer-paced), optional PARITY, STOP.
// All outputs are registered decodes of the state register.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = uart_tx_ctrl_pkg::DATA_WIDTH,
    parameter int STOP_BITS  = 1    // 1 or 2
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);

    tx_state_t             state;
    tx_ctl_t               ctl_q;
    logic                  frame_done_q;
    logic                  stop_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_q;

    logic                  accept;
    logic                  last_stop;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  typ_d;
    logic                  par_w;

    assign accept    = (state == TX_IDLE) && bus.Data_Valid;
    assign last_stop = (STOP_BITS == 1) || stop_cnt;

    // Parity is computed from the next-cycle latch contents so the registered
    // value is already correct in the START cycle.
    assign data_d = accept ? bus.P_DATA  : data_q;
    assign typ_d  = accept ? bus.PAR_TYP : par_typ_q;

    uart_tx_ctrl_parity #(.WIDTH(DATA_WIDTH)) u_par (
        .data (data_d),
        .odd  (typ_d),
        .par  (par_w)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= TX_IDLE;
            ctl_q        <= ctl_of(TX_IDLE);
            frame_done_q <= 1'b0;
            stop_cnt     <= 1'b0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_q        <= 1'b0;
        end else begin
            data_q       <= data_d;
            par_typ_q    <= typ_d;
            par_q        <= par_w;
            frame_done_q <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (bus.Data_Valid) begin
                        par_en_q <= bus.PAR_EN;
                        state    <= TX_START;
                        ctl_q    <= ctl_of(TX_START);
                    end
                end
                TX_START: begin
                    state <= TX_DATA;
                    ctl_q <= ctl_of(TX_DATA);
                end
                TX_DATA: begin
                    if (bus.ser_done) begin
                        if (par_en_q) begin
                            state <= TX_PARITY;
                            ctl_q <= ctl_of(TX_PARITY);
                        end else begin
                            state        <= TX_STOP;
                            ctl_q        <= ctl_of(TX_STOP);
                            frame_done_q <= (STOP_BITS == 1);
                        end
                    end
                end
                TX_PARITY: begin
                    state        <= TX_STOP;
                    ctl_q        <= ctl_of(TX_STOP);
                    frame_done_q <= (STOP_BITS == 1);
                end
                TX_STOP: begin
                    if (last_stop) begin
                        state    <= TX_IDLE;
                        ctl_q    <= ctl_of(TX_IDLE);
                        stop_cnt <= 1'b0;
                    end else begin
                        stop_cnt     <= 1'b1;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                    ctl_q <= ctl_of(TX_IDLE);
                end
            endcase
        end
    end

    assign bus.ser_en     = ctl_q.ser_en;
    assign bus.mux_sel    = ctl_q.mux_sel;
    assign bus.busy       = ctl_q.busy;
    assign bus.frame_done = frame_done_q;
    assign bus.par_bit    = par_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench: two sequencers (1 and 2 stop bits), each with a serializer and line-mux model.
module tb_uart_tx_ctrl;
    import uart_tx_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dv, pe, pt;
    logic [7:0]  pd [2];

    logic [1:0]  busy_o, sen_o, fd_o, pb_o, line_o;
    tx_mux_sel_t ms_o [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

        uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(g + 1)) dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus.slave)
        );

        logic [7:0] sreg;
        logic [2:0] scnt;

        assign bus.P_DATA     = pd[g];
        assign bus.Data_Valid = dv[g];
        assign bus.PAR_EN     = pe[g];
        assign bus.PAR_TYP    = pt[g];
        assign bus.ser_done   = bus.ser_en && (scnt == 3'd7);

        // serializer: loads on accept, shifts LSB-first while enabled
        always_ff @(posedge clk) begin
            if (rst) begin
                sreg <= 8'h00;
                scnt <= 3'd0;
            end else if (dv[g] && !bus.busy) begin
                sreg <= pd[g];
                scnt <= 3'd0;
            end else if (bus.ser_en) begin
                sreg <= sreg >> 1;
                scnt <= scnt + 3'd1;
            end
        end

        assign line_o[g] = (bus.mux_sel == SEL_START)  ? 1'b0 :
                           (bus.mux_sel == SEL_DATA)   ? sreg[0] :
                           (bus.mux_sel == SEL_PARITY) ? bus.par_bit : 1'b1;
        assign busy_o[g] = bus.busy;
        assign sen_o[g]  = bus.ser_en;
        assign fd_o[g]   = bus.frame_done;
        assign pb_o[g]   = bus.par_bit;
        assign ms_o[g]   = bus.mux_sel;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One frame: pulse Data_Valid, record the line while busy. At frame cycle
    // 'poke' Data_Valid is re-pulsed and all inputs inverted (must be ignored).
    task automatic send(input int uu, input logic [7:0] d, input logic p_en, input logic p_typ,
                        input logic [31:0] exp_line, input int exp_len, input logic exp_par,
                        input string tag, input int poke);
        int          nb, nsen, fdpos;
        logic [31:0] got;
        logic        sawpar, pb0, pbl;
        @(negedge clk);
        pd[uu] = d; pe[uu] = p_en; pt[uu] = p_typ; dv[uu] = 1'b1;
        @(negedge clk);
        dv[uu] = 1'b0;
        nb = 0; nsen = 0; fdpos = -1; got = '0; sawpar = 1'b0; pb0 = 1'b0; pbl = 1'b0;
        while (busy_o[uu] && nb < 20) begin
            got[nb] = line_o[uu];
            if (sen_o[uu]) nsen++;
            if (fd_o[uu]) fdpos = nb;
            if (ms_o[uu] == SEL_PARITY) sawpar = 1'b1;
            if (nb == 0) pb0 = pb_o[uu];
            pbl = pb_o[uu];
            dv[uu] = (nb == poke);
            if (nb == poke) begin
                pd[uu] = ~d; pe[uu] = ~p_en; pt[uu] = ~p_typ;
            end
            nb++;
            @(negedge clk);
        end
        dv[uu] = 1'b0;
        chk({tag, "_len"},    nb,     exp_len);
        chk({tag, "_line"},   got,    exp_line);
        chk({tag, "_fdone"},  fdpos,  exp_len - 1);
        chk({tag, "_seren"},  nsen,   8);
        chk({tag, "_par"},    pb0,    exp_par);
        chk({tag, "_parhold"}, pbl,   exp_par);
        chk({tag, "_parst"},  sawpar, p_en);
        chk({tag, "_idle"},   busy_o[uu], 1'b0);
    endtask

    initial begin
        int          nfd, nstart, idle, n;
        logic        prev_busy;
        logic [7:0]  rx;

        rst = 1'b1; dv = '0; pe = '0; pt = '0; pd[0] = 8'h00; pd[1] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy",  busy_o, 2'b00);
        chk("rst_seren", sen_o,  2'b00);
        chk("rst_fdone", fd_o,   2'b00);
        chk("rst_par",   pb_o,   2'b00);
        chk("rst_mux0",  ms_o[0], SEL_STOP);
        chk("rst_mux1",  ms_o[1], SEL_STOP);
        chk("rst_line",  line_o, 2'b11);
        rst = 1'b0;

        send(0, 8'hA5, 1'b1, 1'b0, 32'h54A, 11, 1'b0, "a5even", -1);
        send(0, 8'h01, 1'b1, 1'b1, 32'h402, 11, 1'b0, "01odd",  -1);
        send(1, 8'hFF, 1'b0, 1'b0, 32'h7FE, 11, 1'b0, "ff2stop", -1);
        send(1, 8'hA5, 1'b1, 1'b1, 32'hF4A, 12, 1'b1, "a5odd2", -1);
        send(0, 8'h5A, 1'b1, 1'b1, 32'h6B4, 11, 1'b1, "poke",    4);

        // reset during data bit 4
        @(negedge clk);
        pd[0] = 8'hA5; pe[0] = 1'b1; pt[0] = 1'b0; dv[0] = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mr_indata", ms_o[0], SEL_DATA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_busy",  busy_o[0], 1'b0);
        chk("mr_mux",   ms_o[0],   SEL_STOP);
        chk("mr_seren", sen_o[0],  1'b0);
        chk("mr_fdone", fd_o[0],   1'b0);
        @(negedge clk);
        chk("mr_stay",  busy_o[0], 1'b0);
        send(0, 8'h3C, 1'b0, 1'b0, 32'h278, 10, 1'b0, "3c", -1);

        // Data_Valid held for 40 cycles
        @(negedge clk);
        pd[0] = 8'h96; pe[0] = 1'b1; pt[0] = 1'b0; dv[0] = 1'b1;
        nfd = 0; nstart = 0; idle = 0; prev_busy = 1'b0; rx = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ms_o[0] == SEL_DATA) rx = {line_o[0], rx[7:1]};
            if (fd_o[0]) begin
                nfd++;
                chk("hold_byte", rx, 8'h96);
            end
            if (busy_o[0] && !prev_busy && nstart > 0) chk("hold_gap", idle, 1);
            if (busy_o[0] && !prev_busy) nstart++;
            idle = busy_o[0] ? 0 : idle + 1;
            prev_busy = busy_o[0];
        end
        dv[0] = 1'b0;
        chk("hold_frames", nfd, 3);
        n = 0;
        while (busy_o[0] && n < 20) begin
            @(negedge clk);
            if (ms_o[0] == SEL_DATA) rx = {line_o[0], rx[7:1]};
            if (fd_o[0]) chk("drain_byte", rx, 8'h96);
            n++;
        end
        chk("drain_idle", busy_o[0], 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
